// File: rtl/line_raster_pkg.sv
// Shared types, step constants and width helper for the Bresenham line rasteriser.
package line_raster_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic signed [1:0] STEP_POS = 2'sb01;
  localparam logic signed [1:0] STEP_NEG = 2'sb11;

  // Error term needs one sign bit plus one headroom bit above the widest coordinate.
  function automatic int err_width(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/line_raster_if.sv
// Command and pixel-stream bundle between a line requester and the rasteriser.
interface line_raster_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          start;
  logic          abort;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic          busy;
  logic          done;
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_last;

  modport master (
    output start, abort, x0, x1, y0, y1, pix_ready,
    input  busy, done, pix_valid, pix_x, pix_y, pix_last
  );

  modport slave (
    input  start, abort, x0, x1, y0, y1, pix_ready,
    output busy, done, pix_valid, pix_x, pix_y, pix_last
  );
endinterface

// File: rtl/line_raster.sv
// Bresenham line rasteriser: latches two endpoints on start and streams every
// pixel of the line (all eight octants) over a valid/ready handshake.
module line_raster
  import line_raster_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input logic         clk,
  input logic         reset,
  line_raster_if.slave bus
);

  localparam int EW = err_width(XW, YW);
  typedef logic signed [EW-1:0] sw_t;
  typedef logic signed [EW:0]   sw2_t;

  state_t            state;
  logic [XW-1:0]     xe;
  logic [YW-1:0]     ye;
  sw_t               dx, dy, err;
  logic signed [1:0] sx, sy;

  sw_t           xc_s, yc_s, xe_s, ye_s, adx, ady, err_nxt;
  sw2_t          e2, dx_w, dy_w;
  logic          step_x, step_y, at_end_nxt, hs;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  function automatic sw_t abs_diff(input sw_t a, input sw_t b);
    return (a >= b) ? a - b : b - a;
  endfunction

  always_comb begin
    xc_s    = sw_t'({{(EW-XW){1'b0}}, bus.pix_x});
    yc_s    = sw_t'({{(EW-YW){1'b0}}, bus.pix_y});
    xe_s    = sw_t'({{(EW-XW){1'b0}}, xe});
    ye_s    = sw_t'({{(EW-YW){1'b0}}, ye});
    adx     = abs_diff(xc_s, xe_s);
    ady     = abs_diff(yc_s, ye_s);
    // Both step decisions use the same pre-update e2, so a diagonal step is one cycle.
    e2      = {err, 1'b0};
    dx_w    = {dx[EW-1], dx};
    dy_w    = {dy[EW-1], dy};
    step_x  = (e2 >= dy_w);
    step_y  = (e2 <= dx_w);
    x_nxt   = step_x ? bus.pix_x + XW'(sx) : bus.pix_x;
    y_nxt   = step_y ? bus.pix_y + YW'(sy) : bus.pix_y;
    err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    at_end_nxt = (x_nxt == xe) && (y_nxt == ye);
    hs      = bus.pix_valid && bus.pix_ready;
  end

  // Control state and all visible outputs; the current point doubles as pix_x/pix_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pix_valid <= 1'b0;
      bus.pix_last  <= 1'b0;
      bus.pix_x     <= '0;
      bus.pix_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= SETUP;
            bus.busy  <= 1'b1;
            bus.pix_x <= bus.x0;
            bus.pix_y <= bus.y0;
          end
        end
        SETUP: begin
          if (bus.abort) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state         <= DRAW;
            bus.pix_valid <= 1'b1;
            bus.pix_last  <= (bus.pix_x == xe) && (bus.pix_y == ye);
          end
        end
        DRAW: begin
          if (bus.abort || (hs && bus.pix_last)) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.pix_valid <= 1'b0;
            bus.pix_last  <= 1'b0;
          end else if (hs) begin
            bus.pix_x    <= x_nxt;
            bus.pix_y    <= y_nxt;
            bus.pix_last <= at_end_nxt;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line geometry is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          xe <= bus.x1;
          ye <= bus.y1;
        end
      end
      SETUP: begin
        dx  <= adx;
        dy  <= -ady;
        err <= adx - ady;
        sx  <= (xe_s >= xc_s) ? STEP_POS : STEP_NEG;
        sy  <= (ye_s >= yc_s) ? STEP_POS : STEP_NEG;
      end
      DRAW: begin
        if (hs && !bus.abort && !bus.pix_last) err <= err_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster: octants, degenerate/vertical lines, backpressure,
// ignored restart, abort and mid-line reset.
module tb_line_raster;
  localparam int XW = 11;
  localparam int YW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  line_raster_if #(.XW(XW), .YW(YW)) bus ();
  line_raster #(.XW(XW), .YW(YW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int qx[$], qy[$], ql[$];
  int mx[$], my[$];
  int hs_cyc, done_cyc, first_vld, stab_err, timed_out, busy_at_done;

  // Reference Bresenham producing the expected pixel list.
  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    mx.delete(); my.delete();
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy; x = ax0; y = ay0;
    for (int k = 0; k < 5000; k++) begin
      mx.push_back(x); my.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Issues one line and records every accepted pixel; rmode 1 = random ready.
  task automatic draw_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int rmode, input int abort_at, input int restart_at);
    int cyc, hx, hy, hl;
    bit stalled, r, ab_done, rs_done;
    qx.delete(); qy.delete(); ql.delete();
    hs_cyc = -1; done_cyc = -1; first_vld = -1; stab_err = 0; timed_out = 0;
    busy_at_done = 0; stalled = 0; ab_done = 0; rs_done = 0; hx = 0; hy = 0; hl = 0;
    @(negedge clk);
    bus.x0 = XW'(ax0); bus.y0 = YW'(ay0); bus.x1 = XW'(ax1); bus.y1 = YW'(ay1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    forever begin
      if (bus.done) begin done_cyc = cyc; busy_at_done = int'(bus.busy); break; end
      if (cyc > 4000) begin timed_out = 1; break; end
      r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.pix_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (stalled && (int'(bus.pix_x) != hx || int'(bus.pix_y) != hy ||
                        int'(bus.pix_last) != hl)) stab_err++;
        if (!rs_done && qx.size() == restart_at) begin
          rs_done = 1;
          bus.x0 = '0; bus.y0 = '0; bus.x1 = XW'(100); bus.y1 = YW'(100);
          bus.start = 1'b1;
        end
        if (!ab_done && qx.size() == abort_at) begin
          ab_done = 1; bus.abort = 1'b1; r = 1'b1;
        end
        if (r) begin
          qx.push_back(int'(bus.pix_x)); qy.push_back(int'(bus.pix_y));
          ql.push_back(int'(bus.pix_last));
          hs_cyc = cyc; stalled = 0;
        end else begin
          hx = int'(bus.pix_x); hy = int'(bus.pix_y); hl = int'(bus.pix_last); stalled = 1;
        end
      end else if (stalled) begin
        stab_err++;
      end
      bus.pix_ready = r;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      cyc++;
    end
    bus.pix_ready = 1'b1; bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.pix_valid); end
    checks++; if (bus.pix_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", bus.pix_last); end
    checks++; if (bus.pix_x !== '0 || bus.pix_y !== '0) begin failures++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", bus.pix_x, bus.pix_y); end
  endtask

  task automatic test_shallow();
    int bad, n;
    model(50, 0, 90, 39);
    draw_line(50, 0, 90, 39, 0, -1, -1);
    n = qx.size();
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL shallow_timeout got=%0d exp=0", timed_out); end
    checks++; if (n !== 41) begin failures++; $display("FAIL shallow_count got=%0d exp=41", n); end
    checks++; if (first_vld !== 1) begin failures++; $display("FAIL shallow_latency got=%0d exp=1", first_vld); end
    checks++; if (n < 1 || qx[0] !== 50 || qy[0] !== 0) begin failures++; $display("FAIL shallow_first got=(%0d,%0d) exp=(50,0)", (n > 0) ? qx[0] : -1, (n > 0) ? qy[0] : -1); end
    checks++; if (n < 1 || qx[n-1] !== 90 || qy[n-1] !== 39 || ql[n-1] !== 1) begin failures++; $display("FAIL shallow_last got_n=%0d exp=(90,39,last)", n); end
    bad = 0;
    for (int i = 1; i < n; i++) if (qx[i] != qx[i-1] + 1) bad++;
    for (int i = 0; i < n; i++) if (ql[i] != ((i == n - 1) ? 1 : 0)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL shallow_xinc_lastflag got=%0d exp=0", bad); end
    bad = (n != mx.size()) ? 1 : 0;
    for (int i = 0; i < n && i < mx.size(); i++) if (qx[i] != mx[i] || qy[i] != my[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL shallow_seq got=%0d exp=0", bad); end
    checks++; if (done_cyc !== hs_cyc + 1) begin failures++; $display("FAIL shallow_done_timing got=%0d exp=%0d", done_cyc, hs_cyc + 1); end
    checks++; if (busy_at_done !== 1) begin failures++; $display("FAIL shallow_busy_in_done got=%0d exp=1", busy_at_done); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL shallow_after_done got=busy%0b done%0b exp=0,0", bus.busy, bus.done); end
  endtask

  task automatic test_octant();
    int ex[10] = '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3};
    int ey[10] = '{4, 4, 3, 3, 2, 2, 1, 1, 0, 0};
    int bad, n;
    draw_line(12, 4, 3, 0, 0, -1, -1);
    n = qx.size();
    checks++; if (n !== 10) begin failures++; $display("FAIL octant_count got=%0d exp=10", n); end
    bad = 0;
    for (int i = 0; i < 10 && i < n; i++) if (qx[i] != ex[i] || qy[i] != ey[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL octant_seq got=%0d exp=0", bad); end
    checks++; if (n < 1 || ql[n-1] !== 1) begin failures++; $display("FAIL octant_lastflag got_n=%0d exp=last", n); end
  endtask

  task automatic test_single_vertical();
    int bad, n;
    draw_line(5, 5, 5, 5, 0, -1, -1);
    n = qx.size();
    checks++; if (n !== 1 || qx[0] !== 5 || qy[0] !== 5 || ql[0] !== 1) begin failures++; $display("FAIL single_pixel got_n=%0d exp=1 at (5,5,last)", n); end
    checks++; if (done_cyc !== hs_cyc + 1) begin failures++; $display("FAIL single_done got=%0d exp=%0d", done_cyc, hs_cyc + 1); end
    draw_line(0, 0, 0, 479, 0, -1, -1);
    n = qx.size();
    checks++; if (n !== 480) begin failures++; $display("FAIL vertical_count got=%0d exp=480", n); end
    bad = 0;
    for (int i = 0; i < n; i++) if (qx[i] != 0 || qy[i] != i) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL vertical_seq got=%0d exp=0", bad); end
  endtask

  task automatic test_backpressure();
    int rx[$], ry[$];
    int bad, n;
    model(0, 0, 799, 479);
    draw_line(0, 0, 799, 479, 0, -1, -1);
    rx = qx; ry = qy;
    draw_line(0, 0, 799, 479, 1, -1, -1);
    n = qx.size();
    checks++; if (n !== 800) begin failures++; $display("FAIL bp_count got=%0d exp=800", n); end
    bad = (n != rx.size() || n != mx.size()) ? 1 : 0;
    for (int i = 0; i < n && i < rx.size() && i < mx.size(); i++)
      if (qx[i] != rx[i] || qy[i] != ry[i] || qx[i] != mx[i] || qy[i] != my[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_seq got=%0d exp=0", bad); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL bp_timeout got=%0d exp=0", timed_out); end
  endtask

  task automatic test_start_during_draw();
    int bad, n;
    model(10, 10, 30, 20);
    draw_line(10, 10, 30, 20, 0, -1, 5);
    n = qx.size();
    bad = (n != mx.size()) ? 1 : 0;
    for (int i = 0; i < n && i < mx.size(); i++) if (qx[i] != mx[i] || qy[i] != my[i]) bad++;
    checks++; if (n !== 21 || bad !== 0) begin failures++; $display("FAIL restart_seq got_n=%0d bad=%0d exp_n=21 bad=0", n, bad); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.pix_valid) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL restart_queued got=%0d exp=0", bad); end
  endtask

  task automatic test_abort();
    int bad, n;
    model(0, 0, 40, 30);
    draw_line(0, 0, 40, 30, 0, 9, -1);
    n = qx.size();
    checks++; if (n !== 10) begin failures++; $display("FAIL abort_count got=%0d exp=10", n); end
    bad = 0;
    for (int i = 0; i < n && i < mx.size(); i++) if (qx[i] != mx[i] || qy[i] != my[i] || ql[i] != 0) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_prefix got=%0d exp=0", bad); end
    checks++; if (done_cyc !== hs_cyc + 1) begin failures++; $display("FAIL abort_done got=%0d exp=%0d", done_cyc, hs_cyc + 1); end
    bad = 0;
    @(negedge clk);
    if (bus.busy) bad++;
    repeat (5) begin
      if (bus.pix_valid || bus.done) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", bad); end
  endtask

  task automatic test_reset_midline();
    int bad, n;
    @(negedge clk);
    bus.x0 = '0; bus.y0 = '0; bus.x1 = XW'(100); bus.y1 = YW'(50);
    bus.start = 1'b1; bus.pix_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (bus.pix_valid !== 1'b1) begin failures++; $display("FAIL midline_active got=%0b exp=1", bus.pix_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pix_last !== 1'b0) begin failures++; $display("FAIL midline_ctrl got=v%0b b%0b d%0b l%0b exp=0", bus.pix_valid, bus.busy, bus.done, bus.pix_last); end
    checks++; if (bus.pix_x !== '0 || bus.pix_y !== '0) begin failures++; $display("FAIL midline_xy got=(%0d,%0d) exp=(0,0)", bus.pix_x, bus.pix_y); end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.pix_valid) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL midline_no_done got=%0d exp=0", bad); end
    model(3, 7, 20, 1);
    draw_line(3, 7, 20, 1, 0, -1, -1);
    n = qx.size();
    bad = (n != mx.size()) ? 1 : 0;
    for (int i = 0; i < n && i < mx.size(); i++) if (qx[i] != mx[i] || qy[i] != my[i]) bad++;
    checks++; if (n !== 18 || bad !== 0) begin failures++; $display("FAIL midline_redraw got_n=%0d bad=%0d exp_n=18 bad=0", n, bad); end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_shallow();
    test_octant();
    test_single_vertical();
    test_backpressure();
    test_start_during_draw();
    test_abort();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
